// File: rtl/demux2a4_desc_condl1_pkg.sv
// Shared definitions for the L1 2:4 byte-lane demultiplexer and its 4:2 transmit peer.
// Both ends use the same phase encoding, so they agree on lane order.
package demux2a4_desc_condl1_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    // Phase 0 carries lanes 0/1, phase 1 carries lanes 2/3.
    typedef enum logic {
        PH_LO01 = 1'b0,
        PH_HI23 = 1'b1
    } phase_e;

endpackage

// File: rtl/demux2a4_desc_condl1_hold_lane.sv
// One byte lane plus its valid: a load-enabled capture register with async clear.
// The byte is forced to zero whenever its valid is low, so a stale value can never be stored.
module demux_hold_lane
    import demux2a4_desc_condl1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              load,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W:0]   q
);

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= {valid, (valid ? data : {DATA_W{1'b0}})};
        end
    end

endmodule

// File: rtl/demux2a4_desc_condl1.sv
// Receive-side 2:4 byte-lane demultiplexer: rebuilds four byte lanes from two
// double-rate lanes using a free-running phase toggle, with registered outputs.
module demux2a4_desc_condl1
    import demux2a4_desc_condl1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic [DATA_W-1:0] data_in0_demuxL1,
    input  logic [DATA_W-1:0] data_in1_demuxL1,
    output logic [DATA_W-1:0] dataout0_demuxL1,
    output logic [DATA_W-1:0] dataout1_demuxL1,
    output logic [DATA_W-1:0] dataout2_demuxL1,
    output logic [DATA_W-1:0] dataout3_demuxL1,
    output logic              validout0,
    output logic              validout1,
    output logic              validout2,
    output logic              validout3,
    output logic              frame_strobe,
    output logic              phase,
    output logic [CNT_W-1:0]  frame_count
);

    phase_e            phase_q;
    logic              lo_edge;
    logic              hi_edge;
    logic              any_vld;
    logic [DATA_W:0]   hold0_p0;
    logic [DATA_W:0]   hold1_p0;
    logic [DATA_W:0]   lane0_p1;
    logic [DATA_W:0]   lane1_p1;
    logic [DATA_W:0]   lane2_p1;
    logic [DATA_W:0]   lane3_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign lo_edge = (phase_q == PH_LO01);
    assign hi_edge = (phase_q == PH_HI23);
    assign phase   = phase_q;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            phase_q <= PH_LO01;
        end else begin
            phase_q <= lo_edge ? PH_HI23 : PH_LO01;
        end
    end

    // Stage p0: hold lanes 0/1 from the phase 0 edge until the frame commits.
    demux_hold_lane #(.DATA_W(DATA_W)) u_hold0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (lo_edge),
        .valid  (valid_in0),
        .data   (data_in0_demuxL1),
        .q      (hold0_p0)
    );

    demux_hold_lane #(.DATA_W(DATA_W)) u_hold1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (lo_edge),
        .valid  (valid_in1),
        .data   (data_in1_demuxL1),
        .q      (hold1_p0)
    );

    // Stage p1: all four lanes commit together on the phase 1 edge.
    demux_hold_lane #(.DATA_W(DATA_W)) u_lane0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (hi_edge),
        .valid  (hold0_p0[DATA_W]),
        .data   (hold0_p0[DATA_W-1:0]),
        .q      (lane0_p1)
    );

    demux_hold_lane #(.DATA_W(DATA_W)) u_lane1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (hi_edge),
        .valid  (hold1_p0[DATA_W]),
        .data   (hold1_p0[DATA_W-1:0]),
        .q      (lane1_p1)
    );

    demux_hold_lane #(.DATA_W(DATA_W)) u_lane2 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (hi_edge),
        .valid  (valid_in0),
        .data   (data_in0_demuxL1),
        .q      (lane2_p1)
    );

    demux_hold_lane #(.DATA_W(DATA_W)) u_lane3 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (hi_edge),
        .valid  (valid_in1),
        .data   (data_in1_demuxL1),
        .q      (lane3_p1)
    );

    assign dataout0_demuxL1 = lane0_p1[DATA_W-1:0];
    assign dataout1_demuxL1 = lane1_p1[DATA_W-1:0];
    assign dataout2_demuxL1 = lane2_p1[DATA_W-1:0];
    assign dataout3_demuxL1 = lane3_p1[DATA_W-1:0];
    assign validout0        = lane0_p1[DATA_W];
    assign validout1        = lane1_p1[DATA_W];
    assign validout2        = lane2_p1[DATA_W];
    assign validout3        = lane3_p1[DATA_W];

    assign any_vld = hold0_p0[DATA_W] | hold1_p0[DATA_W] | valid_in0 | valid_in1;

    // Empty frames still strobe but leave the frame counter untouched.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            frame_strobe <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_strobe <= hi_edge;
            if (hi_edge && any_vld) begin
                frame_count <= sat_inc(frame_count);
            end
        end
    end

endmodule

// File: tb/tb_demux2a4_desc_condl1.sv
// Bench for the 2:4 lane demultiplexer: vector table, reset/partial-frame sequence,
// random loopback frames and counter saturation against a frame-level model.
module tb_demux2a4_desc_condl1;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk_2f;
    logic              reset;
    logic              valid_in0;
    logic              valid_in1;
    logic [DATA_W-1:0] data_in0_demuxL1;
    logic [DATA_W-1:0] data_in1_demuxL1;
    logic [DATA_W-1:0] dataout0_demuxL1;
    logic [DATA_W-1:0] dataout1_demuxL1;
    logic [DATA_W-1:0] dataout2_demuxL1;
    logic [DATA_W-1:0] dataout3_demuxL1;
    logic              validout0;
    logic              validout1;
    logic              validout2;
    logic              validout3;
    logic              frame_strobe;
    logic              phase;
    logic [CNT_W-1:0]  frame_count;

    demux2a4_desc_condl1 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_2f           (clk_2f),
        .reset            (reset),
        .valid_in0        (valid_in0),
        .valid_in1        (valid_in1),
        .data_in0_demuxL1 (data_in0_demuxL1),
        .data_in1_demuxL1 (data_in1_demuxL1),
        .dataout0_demuxL1 (dataout0_demuxL1),
        .dataout1_demuxL1 (dataout1_demuxL1),
        .dataout2_demuxL1 (dataout2_demuxL1),
        .dataout3_demuxL1 (dataout3_demuxL1),
        .validout0        (validout0),
        .validout1        (validout1),
        .validout2        (validout2),
        .validout3        (validout3),
        .frame_strobe     (frame_strobe),
        .phase            (phase),
        .frame_count      (frame_count)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    typedef struct {
        logic [7:0]  d0, d1, d2, d3;
        logic [3:0]  v;
        logic [31:0] e;
        logic [3:0]  ev;
    } vec_t;

    vec_t        tbl [4];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_data = '0;
    logic [3:0]  exp_vld  = '0;
    int          exp_cnt  = 0;

    function automatic logic [31:0] dout_all();
        return {dataout3_demuxL1, dataout2_demuxL1, dataout1_demuxL1, dataout0_demuxL1};
    endfunction

    function automatic logic [3:0] vout_all();
        return {validout3, validout2, validout1, validout0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One full frame: lanes 0/1 on the first edge, lanes 2/3 on the second.
    task automatic frame(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3, input logic [3:0] v);
        data_in0_demuxL1 = a0;
        data_in1_demuxL1 = a1;
        valid_in0        = v[0];
        valid_in1        = v[1];
        @(posedge clk_2f); #1;
        chk("mid_phase", 32'(phase), 32'd1);
        chk("mid_strobe", 32'(frame_strobe), 32'd0);
        chk("mid_data_stable", dout_all(), exp_data);
        chk("mid_vld_stable", 32'(vout_all()), 32'(exp_vld));
        chk("mid_cnt_stable", 32'(frame_count), 32'(exp_cnt));
        data_in0_demuxL1 = a2;
        data_in1_demuxL1 = a3;
        valid_in0        = v[2];
        valid_in1        = v[3];
        @(posedge clk_2f); #1;
        exp_data = {(v[3] ? a3 : 8'h00), (v[2] ? a2 : 8'h00),
                    (v[1] ? a1 : 8'h00), (v[0] ? a0 : 8'h00)};
        exp_vld  = v;
        if (v != 4'h0 && exp_cnt < CMAX) exp_cnt++;
        chk("frm_data", dout_all(), exp_data);
        chk("frm_vld", 32'(vout_all()), 32'(exp_vld));
        chk("frm_cnt", 32'(frame_count), 32'(exp_cnt));
        chk("frm_strobe", 32'(frame_strobe), 32'd1);
        chk("frm_phase", 32'(phase), 32'd0);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        exp_data = '0;
        exp_vld  = '0;
        exp_cnt  = 0;
        chk("rst_data", dout_all(), 32'h0);
        chk("rst_vld", 32'(vout_all()), 32'h0);
        chk("rst_strobe", 32'(frame_strobe), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_cnt", 32'(frame_count), 32'h0);
        @(negedge clk_2f);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{d0:8'hA1, d1:8'hB2, d2:8'hC3, d3:8'hD4, v:4'b1111, e:32'hD4C3B2A1, ev:4'b1111};
        tbl[1] = '{d0:8'h11, d1:8'hFF, d2:8'hEE, d3:8'h44, v:4'b1001, e:32'h44000011, ev:4'b1001};
        tbl[2] = '{d0:8'h55, d1:8'h66, d2:8'h77, d3:8'h88, v:4'b0000, e:32'h00000000, ev:4'b0000};
        tbl[3] = '{d0:8'h01, d1:8'h02, d2:8'h03, d3:8'h04, v:4'b0110, e:32'h00030200, ev:4'b0110};

        reset            = 1'b1;
        valid_in0        = 1'b0;
        valid_in1        = 1'b0;
        data_in0_demuxL1 = '0;
        data_in1_demuxL1 = '0;
        #12;
        chk("init_data", dout_all(), 32'h0);
        chk("init_vld", 32'(vout_all()), 32'h0);
        chk("init_phase", 32'(phase), 32'h0);
        chk("init_strobe", 32'(frame_strobe), 32'h0);
        chk("init_cnt", 32'(frame_count), 32'h0);
        @(negedge clk_2f);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            frame(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].v);
            chk("tbl_data", dout_all(), tbl[i].e);
            chk("tbl_vld", 32'(vout_all()), 32'(tbl[i].ev));
        end
        chk("tbl_cnt", 32'(frame_count), 32'd3);

        // Reset with a phase 0 capture pending: the partial frame must vanish.
        frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 4'hF);
        data_in0_demuxL1 = 8'h5A;
        data_in1_demuxL1 = 8'hA5;
        valid_in0        = 1'b1;
        valid_in1        = 1'b1;
        @(posedge clk_2f); #1;
        chk("pend_phase", 32'(phase), 32'd1);
        pulse_reset();
        frame(8'h12, 8'h34, 8'h56, 8'h78, 4'b1110);
        chk("post_rst_data", dout_all(), 32'h78563400);

        for (int i = 0; i < 60; i++) begin
            frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  4'($urandom_range(0, 15)));
        end

        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'hF);
        end
        chk("sat_cnt", 32'(frame_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
